datain_buf_rx: RTL and testbench

- Ejection-side receiver for one NoC tile. It is the sink counterpart of the per-tile injection buffers.
- Accepts 20-bit flits from the router local output port, framed with head/body/tail markers, and stores one packet of DEPTH flits in internal memory.
- Validates the framing, reports completion and errors, and exposes a registered read port so the testbench or a host can read the packet back.
- Runs one packet per arm cycle: after a packet completes, the block must be re-armed by dropping `enable` and raising it again.

---
 rtl/noc_flit_pkg.sv | 31 +++
 rtl/datain_buf_mem.sv | 52 +++++
 rtl/datain_buf_rx.sv | 188 ++++++++++++++++++
 tb/tb_datain_buf_rx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg
//   Shared definitions for the NoC flit format and the ejection receiver.
//   Flit layout: [19:18] type, [17:0] payload.
//   No ports (package). Imported by datain_buf_mem and datain_buf_rx.
package noc_flit_pkg;

  localparam int FLIT_W    = 20;
  localparam int PKT_DEPTH = 30;

  // Position of the two-bit type field inside a flit
  localparam int TYPE_HI = 19;
  localparam int TYPE_LO = 18;

  localparam logic [1:0] FLIT_HEAD = 2'b10;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;
  localparam logic [1:0] FLIT_RSVD = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_WAIT_HEAD = 2'd1,
    RX_RECV      = 2'd2,
    RX_DONE      = 2'd3
  } rx_state_t;

  // Extract the type field of a flit
  function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
    return flit[TYPE_HI:TYPE_LO];
  endfunction

endpackage

// File: rtl/datain_buf_mem.sv
// datain_buf_mem
//   Packet storage for the ejection receiver: DEPTH x DATA_W, one write
//   port and one registered read port. A read of the address being written
//   in the same cycle returns the old contents. Addresses >= DEPTH read 0.
//   The array itself is never cleared by reset; only rd_data is.
// Ports:
//   clk      in   clock, rising edge
//   RST      in   synchronous active-high reset (clears rd_data only)
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  registered read data
module datain_buf_mem
  import noc_flit_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int DEPTH  = PKT_DEPTH,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; the array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; out-of-range addresses return zero
  always_ff @(posedge clk) begin
    if (RST) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < DEPTH_V) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/datain_buf_rx.sv
// datain_buf_rx
//   Ejection-side packet receiver for one NoC tile. Accepts framed flits
//   from the router local port, stores one packet of DEPTH flits, checks
//   framing and reports done/error. One packet per arm: after DONE the
//   block waits for enable to drop before it can be re-armed.
//   Optional macro DATAIN_BUF_RX_CHECKSUM_EN adds a running XOR over the
//   head/body payloads, checks it against the tail payload, and adds chk_ok.
// Ports:
//   clk       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   enable    in   arm receiver (level)
//   in_valid  in   datain carries a flit
//   datain    in   flit, [19:18] type, [17:0] payload
//   rd_addr   in   readback address
//   rd_data   out  mem[rd_addr], one cycle latency
//   flit_cnt  out  flits stored in current packet
//   busy      out  receiving a packet
//   rx_done   out  packet complete without error (level while done)
//   rx_err    out  sticky framing error
//   chk_ok    out  (checksum build only) checksum matched, high while done
module datain_buf_rx
  import noc_flit_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int DEPTH  = PKT_DEPTH,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] datain,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   flit_cnt,
  output logic              busy,
  output logic              rx_done,
  output logic              rx_err
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
  ,
  output logic              chk_ok
`endif
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  rx_state_t         state, state_n;
  logic [ADDR_W:0]   cnt_n;
  logic              err_n;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        ftype;

  assign ftype = flit_type(datain);
  assign busy  = (state == RX_RECV);

`ifdef DATAIN_BUF_RX_CHECKSUM_EN
  logic [TYPE_LO-1:0] payload;
  logic [TYPE_LO-1:0] acc, acc_n;
  logic               chk_q, chk_n;

  assign payload = datain[TYPE_LO-1:0];
  assign chk_ok  = (state == RX_DONE) && chk_q;
`endif

  // State and status registers; rx_done is registered from the next state
  // so it rises together with entry into DONE
  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= RX_IDLE;
      flit_cnt <= '0;
      rx_err   <= 1'b0;
      rx_done  <= 1'b0;
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
      acc      <= '0;
      chk_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      flit_cnt <= cnt_n;
      rx_err   <= err_n;
      rx_done  <= (state_n == RX_DONE) && !err_n;
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
      acc      <= acc_n;
      chk_q    <= chk_n;
`endif
    end
  end

  // Next-state and write control. In RECV every valid flit is stored even
  // when it is a framing error, so the host can inspect the bad packet.
  always_comb begin
    state_n = state;
    cnt_n   = flit_cnt;
    err_n   = rx_err;
    we      = 1'b0;
    wr_addr = flit_cnt[ADDR_W-1:0];
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
    acc_n   = acc;
    chk_n   = chk_q;
`endif
    case (state)
      RX_IDLE: begin
        if (enable) begin
          state_n = RX_WAIT_HEAD;
          cnt_n   = '0;
          err_n   = 1'b0;
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
          acc_n   = '0;
          chk_n   = 1'b0;
`endif
        end
      end
      RX_WAIT_HEAD: begin
        if (!enable) begin
          state_n = RX_IDLE;
        end else if (in_valid) begin
          if (ftype == FLIT_HEAD) begin
            we      = 1'b1;
            wr_addr = '0;
            cnt_n   = CNT_ONE;
            state_n = RX_RECV;
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
            acc_n   = payload;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RX_RECV: begin
        if (in_valid) begin
          we    = 1'b1;
          cnt_n = flit_cnt + CNT_ONE;
          if (ftype == FLIT_TAIL) begin
            state_n = RX_DONE;
            if (flit_cnt != LAST_IDX) begin
              err_n = 1'b1;
            end
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
            chk_n = (payload == acc);
            if (payload != acc) begin
              err_n = 1'b1;
            end
`endif
          end else if (flit_cnt == LAST_IDX) begin
            // Slot DEPTH-1 filled by a non-tail flit: packet is overlong
            err_n   = 1'b1;
            state_n = RX_DONE;
          end else begin
            if (ftype != FLIT_BODY) begin
              err_n = 1'b1;
            end
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
            if (ftype == FLIT_BODY || ftype == FLIT_HEAD) begin
              acc_n = acc ^ payload;
            end
`endif
          end
        end
      end
      RX_DONE: begin
        if (!enable) begin
          state_n = RX_IDLE;
        end
      end
      default: begin
        state_n = RX_IDLE;
      end
    endcase
  end

  datain_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .RST     (RST),
    .we      (we && !RST),
    .wr_addr (wr_addr),
    .wr_data (datain),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_datain_buf_rx.sv
// tb_datain_buf_rx
//   Bench for datain_buf_rx: directed packets from the test plan followed by
//   randomized packets, all compared every cycle against a packet-level
//   reference model, plus hand-computed literal expectations.
//   Honours DATAIN_BUF_RX_CHECKSUM_EN when defined.
module tb_datain_buf_rx;

  localparam int DEPTH = 30;

  logic        clk = 1'b0;
  logic        RST;
  logic        enable;
  logic        in_valid;
  logic [19:0] datain;
  logic [4:0]  rd_addr;
  logic [19:0] rd_data;
  logic [5:0]  flit_cnt;
  logic        busy;
  logic        rx_done;
  logic        rx_err;
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
  logic        chk_ok;
`endif

  int checks = 0;
  int errors = 0;
  bit rd_hold = 0;

  always #5 clk = ~clk;

  datain_buf_rx dut (
    .clk      (clk),
    .RST      (RST),
    .enable   (enable),
    .in_valid (in_valid),
    .datain   (datain),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .flit_cnt (flit_cnt),
    .busy     (busy),
    .rx_done  (rx_done),
    .rx_err   (rx_err)
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
    ,
    .chk_ok   (chk_ok)
`endif
  );

  // Reference model: a packet is "armed", "has its head" and "finished";
  // the stored packet is an array with a known-flag per slot
  bit          m_live = 0;
  bit          m_armed, m_head, m_fin, m_err, m_chk;
  logic [5:0]  m_cnt;
  logic [17:0] m_xor;
  logic [19:0] m_mem [32];
  bit          m_known [32];
  logic [19:0] m_rd;
  bit          m_rd_known;

  task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [1:0]  t;
    logic [17:0] p;
    t = datain[19:18];
    p = datain[17:0];
    if (RST) begin
      m_live = 1; m_armed = 0; m_head = 0; m_fin = 0; m_err = 0; m_chk = 0;
      m_cnt = 0; m_xor = 0; m_rd = 0; m_rd_known = 1;
    end else begin
      if (rd_addr < DEPTH) begin
        m_rd = m_mem[rd_addr];
        m_rd_known = m_known[rd_addr];
      end else begin
        m_rd = 0;
        m_rd_known = 1;
      end
      if (!m_armed) begin
        if (enable) begin
          m_armed = 1; m_head = 0; m_fin = 0; m_err = 0; m_chk = 0; m_cnt = 0; m_xor = 0;
        end
      end else if (m_fin) begin
        if (!enable) m_armed = 0;
      end else if (!m_head) begin
        if (!enable) m_armed = 0;
        else if (in_valid) begin
          if (t == 2'b10) begin
            m_mem[0] = datain; m_known[0] = 1; m_cnt = 1; m_head = 1; m_xor = p;
          end else m_err = 1;
        end
      end else if (in_valid) begin
        m_mem[m_cnt] = datain;
        m_known[m_cnt] = 1;
        m_cnt = m_cnt + 1;
        if (t == 2'b01) begin
          m_fin = 1;
          if (m_cnt != DEPTH) m_err = 1;
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
          m_chk = (p == m_xor);
          if (p != m_xor) m_err = 1;
`endif
        end else if (m_cnt == DEPTH) begin
          m_fin = 1; m_err = 1;
        end else begin
          if (t != 2'b00) m_err = 1;
          if (t == 2'b00 || t == 2'b10) m_xor = m_xor ^ p;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("flit_cnt", flit_cnt, m_cnt);
      checkOutput("busy", busy, m_armed && m_head && !m_fin);
      checkOutput("rx_done", rx_done, m_armed && m_fin && !m_err);
      checkOutput("rx_err", rx_err, m_err);
      if (m_rd_known) checkOutput("rd_data", rd_data, m_rd);
`ifdef DATAIN_BUF_RX_CHECKSUM_EN
      checkOutput("chk_ok", chk_ok, m_armed && m_fin && m_chk);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [19:0] d);
    in_valid = v;
    datain   = d;
    if (!rd_hold) rd_addr = 5'($urandom_range(0, 31));
    tick();
  endtask

  task automatic rearm();
    enable = 0;
    applyStimulus(0, 20'h0);
    enable = 1;
    applyStimulus(0, 20'h0);
  endtask

  function automatic logic [19:0] goodFlit(input int i);
    if (i == 0) return 20'h80001;
    if (i == DEPTH - 1) return 20'h4001E;
    return 20'(i + 1);
  endfunction

  initial begin
    logic [19:0] f;
    logic [17:0] x;
    int len;
    for (int i = 0; i < 32; i++) m_known[i] = 0;
    RST = 1; enable = 0; in_valid = 0; datain = 0; rd_addr = 0;
    repeat (3) tick();
    checkOutput("reset_flit_cnt", flit_cnt, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rx_done", rx_done, 0);
    checkOutput("reset_rx_err", rx_err, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    RST = 0; enable = 1;
    applyStimulus(0, 20'h0);
    checkOutput("wait_head_busy", busy, 0);

    // Back-to-back good packet
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, goodFlit(i));
      if (i == 10) checkOutput("b2b_busy_mid", busy, 1);
    end
    checkOutput("b2b_flit_cnt", flit_cnt, 30);
`ifndef DATAIN_BUF_RX_CHECKSUM_EN
    checkOutput("b2b_rx_done", rx_done, 1);
    checkOutput("b2b_rx_err", rx_err, 0);
`endif
    applyStimulus(0, 20'h0);

    // Readback of the whole packet plus out-of-range addresses
    rd_hold = 1;
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      tick();
      checkOutput("readback", rd_data, (a < DEPTH) ? goodFlit(a) : 20'h0);
    end
    rd_addr = 0;  tick(); checkOutput("readback_head_lit", rd_data, 20'h80001);
    rd_addr = 29; tick(); checkOutput("readback_tail_lit", rd_data, 20'h4001E);
    rd_addr = 10; tick(); checkOutput("readback_mid_lit", rd_data, 20'h0000B);
    rd_hold = 0;

    // Gapped packet, valid toggling every cycle
    rearm();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, goodFlit(i));
      applyStimulus(0, 20'hFFFFF);
      if (i < DEPTH - 1) checkOutput("gap_busy", busy, 1);
    end
    checkOutput("gap_flit_cnt", flit_cnt, 30);
`ifndef DATAIN_BUF_RX_CHECKSUM_EN
    checkOutput("gap_rx_done", rx_done, 1);
`endif

    // Stray body flit before the head
    rearm();
    applyStimulus(1, 20'h00005);
    checkOutput("stray_rx_err", rx_err, 1);
    checkOutput("stray_busy", busy, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, goodFlit(i));
    checkOutput("stray_rx_done", rx_done, 0);
    checkOutput("stray_flit_cnt", flit_cnt, 30);
    checkOutput("stray_busy_done", busy, 0);

    // Short packet: tail at index 10
    rearm();
    for (int i = 0; i < 10; i++) applyStimulus(1, goodFlit(i));
    applyStimulus(1, 20'h4000B);
    checkOutput("short_flit_cnt", flit_cnt, 11);
    checkOutput("short_rx_err", rx_err, 1);
    checkOutput("short_rx_done", rx_done, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 20'h00077);
    checkOutput("short_ignored_cnt", flit_cnt, 11);
    enable = 0;
    applyStimulus(0, 20'h0);
    enable = 1;
    applyStimulus(0, 20'h0);
    checkOutput("rearm_clears_err", rx_err, 0);
    checkOutput("rearm_clears_cnt", flit_cnt, 0);

    // Reset in the middle of a packet
    for (int i = 0; i < 15; i++) applyStimulus(1, goodFlit(i));
    checkOutput("midrst_busy_before", busy, 1);
    checkOutput("midrst_cnt_before", flit_cnt, 15);
    enable = 0;
    RST = 1;
    applyStimulus(0, 20'h0);
    RST = 0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_flit_cnt", flit_cnt, 0);
    for (int i = 15; i < DEPTH; i++) applyStimulus(1, goodFlit(i));
    checkOutput("midrst_ignored_cnt", flit_cnt, 0);
    checkOutput("midrst_ignored_busy", busy, 0);

    // Randomized packets: random length, payloads, gaps, stray/odd types, resets
    for (int pk = 0; pk < 25; pk++) begin
      rearm();
      len = $urandom_range(1, 34);
      x = 0;
      for (int i = 0; i < len; i++) begin
        f[17:0] = 18'($urandom);
        if (i == 0) f[19:18] = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b10;
        else if (i == len - 1) begin
          f[19:18] = 2'b01;
          if ($urandom_range(0, 1) == 1) f[17:0] = x;
        end else begin
          case ($urandom_range(0, 19))
            0:       f[19:18] = 2'b11;
            1:       f[19:18] = 2'b10;
            default: f[19:18] = 2'b00;
          endcase
        end
        if (i != len - 1 && f[19:18] != 2'b11) x = x ^ f[17:0];
        while ($urandom_range(0, 3) == 0) applyStimulus(0, 20'($urandom));
        if ($urandom_range(0, 49) == 0) begin
          RST = 1;
          applyStimulus(1, f);
          RST = 0;
        end else begin
          applyStimulus(1, f);
        end
      end
      repeat (2) applyStimulus(0, 20'h0);
    end

`ifdef DATAIN_BUF_RX_CHECKSUM_EN
    // Checksum: matching tail, then one flipped bit
    for (int pass = 0; pass < 2; pass++) begin
      rearm();
      x = 0;
      for (int i = 0; i < DEPTH - 1; i++) begin
        f = {(i == 0) ? 2'b10 : 2'b00, 18'($urandom)};
        x = x ^ f[17:0];
        applyStimulus(1, f);
      end
      applyStimulus(1, {2'b01, (pass == 0) ? x : (x ^ 18'h00001)});
      checkOutput("chk_ok_lit", chk_ok, (pass == 0) ? 1 : 0);
      checkOutput("chk_rx_err_lit", rx_err, (pass == 0) ? 0 : 1);
      checkOutput("chk_rx_done_lit", rx_done, (pass == 0) ? 1 : 0);
    end
`endif

    enable = 0;
    repeat (3) applyStimulus(0, 20'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
